// File: rtl/excess3_pkg.sv
// Shared definitions for the Excess-3 receive path: packer FSM states and
// the code offset / legal code window.
package excess3_pkg;

  typedef enum logic {
    ACC   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN    = 4'd3;
  localparam logic [3:0] E3_MAX    = 4'd12;

endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational Excess-3 digit decoder: code - 3 for legal codes, digit 0
// plus an invalid flag for codes outside 3..12.
module excess3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    invalid = (code < E3_MIN) || (code > E3_MAX);
    bcd     = invalid ? 4'd0 : code - E3_OFFSET;
  end

endmodule

// File: rtl/excess3_to_bcd_packer.sv
// Streaming Excess-3 to BCD packer with an accumulator and an output register.
// Define EXCESS3_ERR_COUNT_EN to add the saturating err_count port.
module excess3_to_bcd_packer
  import excess3_pkg::*;
#(
  parameter int DIGITS = 4,
  localparam int CNT_W = $clog2(DIGITS + 1),
  localparam int BCD_W = 4 * DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] out_bcd,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
`ifdef EXCESS3_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DIGITS);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic [3:0]       dec_bcd;
  logic             dec_invalid;
  logic [BCD_W+3:0] shifted;
  logic [BCD_W-1:0] next_acc;
  logic [CNT_W-1:0] next_cnt;
  logic             next_err;
  logic             accept, drain, complete;

  excess3_digit_decode u_decode (
    .code    (in_digit),
    .bcd     (dec_bcd),
    .invalid (dec_invalid)
  );

  always_comb begin
    shifted     = {acc_q, dec_bcd};
    next_acc    = shifted[BCD_W-1:0];
    next_cnt    = cnt_q + CNT_W'(1);
    next_err    = err_q | dec_invalid;
    accept      = in_valid && (state_q == ACC);
    drain       = out_valid_q && out_ready;
    complete    = accept && (in_last || (next_cnt == MAX_CNT));

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q && !drain;
    out_bcd_d   = out_bcd_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;

    case (state_q)
      ACC: begin
        if (complete && (!out_valid_q || drain)) begin
          out_valid_d = 1'b1;
          out_bcd_d   = next_acc;
          out_count_d = next_cnt;
          out_err_d   = next_err;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
        end else if (accept) begin
          // A completed word that cannot leave yet parks in the accumulator.
          acc_d = next_acc;
          cnt_d = next_cnt;
          err_d = next_err;
          if (complete) state_d = STALL;
        end
      end
      STALL: begin
        if (drain) begin
          out_valid_d = 1'b1;
          out_bcd_d   = acc_q;
          out_count_d = cnt_q;
          out_err_d   = err_q;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

`ifdef EXCESS3_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && dec_invalid && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/excess3_to_bcd_packer.md
# excess3_to_bcd_packer

Streaming Excess-3 to BCD decoder and packer, the receive-side counterpart of the team's BCD-to-Excess-3 encoder. It accepts one Excess-3 digit per cycle over a valid/ready handshake, most-significant digit first, subtracts 3, validates each code and packs up to DIGITS BCD digits into one right-aligned word. Packed words leave on a second valid/ready handshake. Sits between the Excess-3 digit link and the BCD arithmetic/display path.

## Interface
- DIGITS, default 4: maximum digits per packed word; legal range 1..8.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an Excess-3 digit is offered.
- in_ready  output  1  the digit is accepted when in_valid && in_ready.
- in_digit  input  4  Excess-3 code.
- in_last  input  1  this digit closes the current word early.
- out_valid  output  1  a packed word is held on the output.
- out_ready  input  1  the word is consumed when out_valid && out_ready.
- out_bcd  output  4*DIGITS  packed BCD; the last digit received is in bits [3:0].
- out_count  output  $clog2(DIGITS+1)  number of digits in the word, 1..DIGITS.
- out_err  output  1  at least one digit in the word had an invalid code.
- err_count  output  8  saturating count of invalid digits; present only with EXCESS3_ERR_COUNT_EN.

## Operation
- Decode: a code in 3..12 gives bcd = code - 3, as 4-bit modulo arithmetic.
- Codes 0, 1, 2, 13, 14 and 15 are invalid. An invalid code inserts digit 0 and sets the sticky error flag for the word.
- Accumulator shift on each accepted digit: acc <= {acc[4*DIGITS-5:0], bcd}. The digit count increments and the error flag ORs in.
- A word completes on the accepted digit that has in_last = 1, or on the digit that brings the count to DIGITS. in_last on the DIGITS-th digit is redundant and produces no extra word.
- Partial words stay right-aligned, with zeros in the unused upper digits.
- There are two storage stages: the accumulator and the output register (out_bcd/out_count/out_err plus out_valid).
- State machine:
  - ACC: in_ready = 1.
    - A completing digit with the output register empty, or draining this cycle: the word goes to the output register, and the accumulator, count and error flag clear.
    - A completing digit with the output register full and not draining: go to STALL, with the completed word held in the accumulator.
  - STALL: in_ready = 0. When out_ready drains the output, the accumulator transfers to the output register in that same cycle, the accumulator clears, and the state returns to ACC.
- Simultaneous output drain and word completion in ACC: the new word loads, out_valid stays 1, and there are no bubble cycles.
- in_digit and in_last are ignored when in_valid = 0.

## Timing
- Reset values:
  - out_valid = 0, out_bcd = 0, out_count = 0, out_err = 0.
  - in_ready = 1.
  - state = ACC, accumulator empty.
  - err_count = 0.
- Reset mid-word discards the partial word and any held or stalled word. No word is emitted for pre-reset digits.
- Latency: out_valid rises in the cycle after the completing digit is accepted.
- Throughput: one digit per cycle sustained while out_ready = 1.
- in_ready is a registered state decode. It has no combinational path from out_ready.
- Output stability: out_bcd, out_count and out_err hold constant while out_valid && !out_ready.

## Configuration
- EXCESS3_ERR_COUNT_EN defined: err_count increments by 1 on each accepted invalid digit and saturates at 255. Only rst clears it; word boundaries and stalls do not.
- Undefined: the err_count port and its register are absent. out_err behaviour is unchanged.

## Structure
- Shared package excess3_pkg holds:
  - state enum: ACC, STALL
  - E3_OFFSET = 4'd3
  - E3_MIN = 4'd3
  - E3_MAX = 4'd12
- Sub-module excess3_digit_decode: combinational, 4-bit code in, 4-bit BCD digit plus invalid flag out. It is reusable by other Excess-3 receivers.

## Test plan
- DIGITS=4, out_ready=1; send 0x4, 0x5, 0x6, 0x7 back-to-back -> one cycle later out_bcd=16'h1234, out_count=4, out_err=0; in_ready stays 1 throughout.
- Send 0x7, then 0xF with in_last -> out_bcd=16'h0040, out_count=2, out_err=1; err_count=1 when EXCESS3_ERR_COUNT_EN is defined.
- out_ready=0; send two full words (8 digits) -> first word held stable, second word completes, in_ready=0 on the following cycle; raise out_ready -> 16'h1234 drains, then the second word appears the next cycle and in_ready returns to 1.
- Output full with out_ready=1 in the same cycle a completing digit is accepted -> new word replaces the old with out_valid continuously 1.
- Send 0x4, 0x5, assert rst for one cycle, then send 0xC with in_last -> out_bcd=16'h0009, out_count=1; no pre-reset word appears.
- With the macro defined, send 300 invalid digits -> err_count saturates at 255.
